// File: rtl/rstseq03.sv
// rstseq03: reset sequencer for a three-domain reset synchronizer bank.
// Staged power-on release, round-robin per-domain soft reset, global soft reset.
//
// Ports:
//   clk        control clock (single clock domain)
//   rst_       asynchronous active-low reset
//   dly        gap length; each hold/gap phase lasts dly+1 cycles
//   swrst_all  global software reset pulse (ignored while in HOLD)
//   swrst_req  per-domain software reset request, level until ack
//   rstmsk     per-domain reset mask, 1 = hold domain in reset
//   swrst_ack  one-cycle completion pulse per domain
//   busy       sequencer not in RUN
//   done       release sequence complete, cleared by global reset
module rstseq03 #(
  parameter int DLYW = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [DLYW-1:0] dly,
  input  logic            swrst_all,
  input  logic [2:0]      swrst_req,
  output logic [2:0]      rstmsk,
  output logic [2:0]      swrst_ack,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    HOLD,
    REL0,
    REL1,
    REL2,
    RUN,
    SASSERT,
    SRELEASE
  } state_t;

  localparam logic [DLYW-1:0] ONE = DLYW'(1);

  state_t          state_q;
  logic [DLYW-1:0] cnt_q;
  logic            ld_q;
  logic [1:0]      ptr_q;
  logic [1:0]      gnt_q;
  logic [2:0]      msk_q;
  logic [2:0]      ack_q;
  logic            busy_q;
  logic            done_q;

  logic            cnt_zero;
  logic            gnt_vld;
  logic [1:0]      gnt_idx;
  logic [1:0]      p1;
  logic [1:0]      p2;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // Round-robin pick: first asserted request at or after the pointer.
  always_comb begin
    p1      = nxt(ptr_q);
    p2      = nxt(p1);
    gnt_vld = |swrst_req;
    gnt_idx = p2;
    if (swrst_req[ptr_q]) begin
      gnt_idx = ptr_q;
    end else if (swrst_req[p1]) begin
      gnt_idx = p1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ld_q    <= 1'b1;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      msk_q   <= 3'b111;
      ack_q   <= 3'b000;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ack_q <= 3'b000;
      if (swrst_all && (state_q != HOLD)) begin
        // Global restart aborts any soft reset without an ack.
        state_q <= HOLD;
        cnt_q   <= dly;
        msk_q   <= 3'b111;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          HOLD: begin
            // First cycle out of reset only loads the counter.
            if (ld_q) begin
              ld_q  <= 1'b0;
              cnt_q <= dly;
            end else if (cnt_zero) begin
              state_q  <= REL0;
              cnt_q    <= dly;
              msk_q[0] <= 1'b0;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          REL0: begin
            if (cnt_zero) begin
              state_q  <= REL1;
              cnt_q    <= dly;
              msk_q[1] <= 1'b0;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          REL1: begin
            if (cnt_zero) begin
              state_q  <= REL2;
              msk_q[2] <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          REL2: begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
          RUN: begin
            if (gnt_vld) begin
              state_q        <= SASSERT;
              gnt_q          <= gnt_idx;
              ptr_q          <= nxt(gnt_idx);
              cnt_q          <= dly;
              msk_q[gnt_idx] <= 1'b1;
              busy_q         <= 1'b1;
            end
          end
          SASSERT: begin
            if (cnt_zero) begin
              state_q      <= SRELEASE;
              msk_q[gnt_q] <= 1'b0;
              ack_q[gnt_q] <= 1'b1;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          SRELEASE: begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= HOLD;
            cnt_q   <= dly;
            msk_q   <= 3'b111;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rstmsk    = msk_q;
  assign swrst_ack = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rstseq03.sv
// tb_rstseq03: self-checking bench for rstseq03.
// Timestamp-based reference model plus directed timing checks.
module tb_rstseq03;

  localparam int DLYW = 8;

  logic            clk = 1'b0;
  logic            rst_;
  logic [DLYW-1:0] dly;
  logic            swrst_all;
  logic [2:0]      swrst_req;
  logic [2:0]      rstmsk;
  logic [2:0]      swrst_ack;
  logic            busy;
  logic            done;

  rstseq03 #(.DLYW(DLYW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .dly       (dly),
    .swrst_all (swrst_all),
    .swrst_req (swrst_req),
    .rstmsk    (rstmsk),
    .swrst_ack (swrst_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc;
  int ack_log[$];

  // Model: mode 0 = release sequence, 1 = idle, 2 = soft reset.
  // stage counts domains released so far; dead is the absolute
  // edge number of the next milestone.
  int         m_mode, m_stage, m_dead, m_g, m_ptr;
  bit         m_rel, m_first;
  logic [2:0] m_msk, m_ack;
  logic       m_busy, m_done;

  function automatic void model_reset();
    m_mode  = 0;
    m_stage = 0;
    m_dead  = -1;
    m_g     = 0;
    m_ptr   = 0;
    m_rel   = 0;
    m_first = 1;
    m_msk   = 3'b111;
    m_ack   = 3'b000;
    m_busy  = 1'b1;
    m_done  = 1'b0;
  endfunction

  function automatic void model_edge(input int n);
    int span;
    span  = int'(dly) + 1;
    m_ack = 3'b000;
    if (m_first) begin
      m_first = 0;
      m_dead  = n + span;
    end else if (swrst_all && !(m_mode == 0 && m_stage == 0)) begin
      m_mode  = 0;
      m_stage = 0;
      m_msk   = 3'b111;
      m_done  = 1'b0;
      m_busy  = 1'b1;
      m_dead  = n + span;
    end else if (m_mode == 0) begin
      if (n == m_dead) begin
        if (m_stage < 3) begin
          m_msk[m_stage] = 1'b0;
          m_stage++;
          if (m_stage == 3) begin
            m_done = 1'b1;
            m_dead = n + 1;
          end else begin
            m_dead = n + span;
          end
        end else begin
          m_mode = 1;
          m_busy = 1'b0;
        end
      end
    end else if (m_mode == 1) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (m_mode == 1 && swrst_req[i]) begin
          m_g      = i;
          m_mode   = 2;
          m_rel    = 0;
          m_msk[i] = 1'b1;
          m_busy   = 1'b1;
          m_ptr    = (i + 1) % 3;
          m_dead   = n + span;
        end
      end
    end else begin
      if (n == m_dead) begin
        if (!m_rel) begin
          m_msk[m_g] = 1'b0;
          m_ack[m_g] = 1'b1;
          m_rel      = 1;
          m_dead     = n + 1;
        end else begin
          m_mode = 1;
          m_busy = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] obs();
    return {rstmsk, swrst_ack, busy, done};
  endfunction

  function automatic logic [7:0] expv();
    return {m_msk, m_ack, m_busy, m_done};
  endfunction

  // One clock: model advances with the inputs the DUT samples,
  // outputs are then observed on the falling edge.
  task automatic tick();
    cyc++;
    model_edge(cyc);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (swrst_ack[i]) ack_log.push_back(i);
    swrst_req = swrst_req & ~m_ack;
    swrst_all = 1'b0;
  endtask

  task automatic do_reset(input logic [DLYW-1:0] d);
    rst_      = 1'b0;
    dly       = d;
    swrst_all = 1'b0;
    swrst_req = 3'b000;
    model_reset();
    ack_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    cyc  = -1;
  endtask

  task automatic test_reset();
    rst_      = 1'b0;
    dly       = 8'd5;
    swrst_all = 1'b1;
    swrst_req = 3'b111;
    #12;
    total++;
    if ({rstmsk, swrst_ack, busy, done} !== 8'b111_000_1_0) begin
      bad++;
      $display("FAIL reset_vals got=%b want=%b",
               {rstmsk, swrst_ack, busy, done}, 8'b111_000_1_0);
    end
  endtask

  task automatic test_poweron(input int d);
    int r;
    logic [2:0] wm;
    do_reset(DLYW'(d));
    r = d + 1;
    repeat (3 * r + 4) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL poweron_d%0d_model cyc=%0d got=%b want=%b",
                 d, cyc, obs(), expv());
      end
      wm = (cyc < r) ? 3'b111 : (cyc < 2 * r) ? 3'b110 :
           (cyc < 3 * r) ? 3'b100 : 3'b000;
      total++;
      if (rstmsk !== wm || done !== (cyc >= 3 * r) ||
          busy !== (cyc < 3 * r + 1)) begin
        bad++;
        $display("FAIL poweron_d%0d_timing cyc=%0d got=%b/%b/%b want=%b/%b/%b",
                 d, cyc, rstmsk, done, busy, wm, cyc >= 3 * r,
                 cyc < 3 * r + 1);
      end
    end
  endtask

  task automatic test_rr();
    int c001, c100;
    int want[5];
    want = '{0, 2, 0, 1, 2};
    c001 = 0;
    c100 = 0;
    dly = 8'd2;
    ack_log.delete();
    swrst_req = 3'b101;
    repeat (14) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL rr_model cyc=%0d got=%b want=%b",
                 cyc, obs(), expv());
      end
      if (rstmsk == 3'b001) c001++;
      if (rstmsk == 3'b100) c100++;
    end
    total++;
    if (c001 != 3 || c100 != 3) begin
      bad++;
      $display("FAIL rr_assert_len got=%0d,%0d want=3,3", c001, c100);
    end
    swrst_req = 3'b111;
    repeat (20) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL rr3_model cyc=%0d got=%b want=%b",
                 cyc, obs(), expv());
      end
    end
    total++;
    if (ack_log.size() != 5) begin
      bad++;
      $display("FAIL rr_order_len got=%0d want=5", ack_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (ack_log[i] != want[i]) begin
          bad++;
          $display("FAIL rr_order[%0d] got=%0d want=%0d",
                   i, ack_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_all_during_sa();
    int t_done, t_ack, n_ack;
    t_done = -1;
    t_ack  = -1;
    n_ack  = 0;
    dly = 8'd2;
    swrst_req = 3'b010;
    repeat (2) tick();
    total++;
    if (rstmsk !== 3'b010 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sa_entry got=%b/%b want=010/1", rstmsk, busy);
    end
    swrst_all = 1'b1;
    tick();
    total++;
    if (rstmsk !== 3'b111 || done !== 1'b0 || busy !== 1'b1 ||
        swrst_ack !== 3'b000) begin
      bad++;
      $display("FAIL sa_abort got=%b/%b/%b/%b want=111/000/1/0",
               rstmsk, swrst_ack, busy, done);
    end
    repeat (20) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL sa_model cyc=%0d got=%b want=%b",
                 cyc, obs(), expv());
      end
      if (done && t_done < 0) t_done = cyc;
      if (swrst_ack[1]) begin
        n_ack++;
        if (t_ack < 0) t_ack = cyc;
      end
    end
    total++;
    if (t_done < 0 || t_ack <= t_done || n_ack != 1) begin
      bad++;
      $display("FAIL sa_pending got=done@%0d ack@%0d n=%0d want=ack after done n=1",
               t_done, t_ack, n_ack);
    end
  endtask

  task automatic test_all_with_req();
    int t_done;
    t_done = -1;
    ack_log.delete();
    swrst_all = 1'b1;
    swrst_req = 3'b100;
    tick();
    total++;
    if (rstmsk !== 3'b111 || done !== 1'b0) begin
      bad++;
      $display("FAIL allreq_first got=%b/%b want=111/0", rstmsk, done);
    end
    repeat (20) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL allreq_model cyc=%0d got=%b want=%b",
                 cyc, obs(), expv());
      end
      if (done && t_done < 0) t_done = cyc;
    end
    total++;
    if (ack_log.size() != 1 || t_done < 0) begin
      bad++;
      $display("FAIL allreq_serve got=acks:%0d done@%0d want=acks:1",
               ack_log.size(), t_done);
    end else if (ack_log[0] != 2) begin
      bad++;
      $display("FAIL allreq_dom got=%0d want=2", ack_log[0]);
    end
  endtask

  task automatic test_async_rst();
    logic [2:0] wm;
    do_reset(8'd4);
    repeat (13) tick();
    total++;
    if (rstmsk !== 3'b100) begin
      bad++;
      $display("FAIL arst_pre got=%b want=100", rstmsk);
    end
    #2 rst_ = 1'b0;
    #1;
    total++;
    if ({rstmsk, swrst_ack, busy, done} !== 8'b111_000_1_0) begin
      bad++;
      $display("FAIL arst_async got=%b want=%b",
               {rstmsk, swrst_ack, busy, done}, 8'b111_000_1_0);
    end
    model_reset();
    dly = 8'd1;
    @(negedge clk);
    rst_ = 1'b1;
    cyc  = -1;
    repeat (9) begin
      tick();
      wm = (cyc < 2) ? 3'b111 : (cyc < 4) ? 3'b110 :
           (cyc < 6) ? 3'b100 : 3'b000;
      total++;
      if (rstmsk !== wm || obs() !== expv()) begin
        bad++;
        $display("FAIL arst_restart cyc=%0d got=%b want=%b msk=%b",
                 cyc, obs(), expv(), wm);
      end
    end
  endtask

  task automatic test_random();
    do_reset(DLYW'($urandom_range(0, 4)));
    repeat (900) begin
      if ($urandom_range(0, 39) == 0) swrst_all = 1'b1;
      if ($urandom_range(0, 5) == 0)
        swrst_req = swrst_req | (3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) dly = DLYW'($urandom_range(0, 4));
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL rand_model cyc=%0d got=%b want=%b",
                 cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_poweron(3);
    test_poweron(0);
    test_rr();
    test_all_during_sa();
    test_all_with_req();
    test_async_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
